// File: rtl/sram_arbiter_if.sv
// Arbiter bundle: fetch port (i_*), data port (d_*) and SRAM controller side (m_*).
// slave = arbiter view, master = masters/controller view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
) ();
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_write;
  logic              d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_select;
  logic              m_ready;
  logic              m_write;
  logic              m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_hready;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_hready,
    output i_done, i_rdata, d_done, d_rdata, d_err,
           m_select, m_ready, m_write, m_size, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_hready,
    input  i_done, i_rdata, d_done, d_rdata, d_err,
           m_select, m_ready, m_write, m_size, m_addr, m_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master (fetch I / data D) arbiter and sequencer in front of the single-port SRAM controller.
// Optional SRAM_ARB_RR_EN: round-robin arbitration instead of fixed D-over-I priority.
//
// state      | meaning
// ST_IDLE    | arbitrate eligible requests, latch winner's fields
// ST_ISSUE   | m_select=m_ready=1 for one cycle, controller captures
// ST_RESP    | wait for m_hready, register read data, bounded by WAIT_MAX
module sram_arbiter #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic            Hclock,
  input  logic            Hreset,
  sram_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_grant_d;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic              r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_select;
  logic              r_i_done;
  logic              r_d_done;
  logic              r_d_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_i_elig;
  logic              w_d_elig;
  logic              w_pick_d;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_timeout;

  // a port is excluded in the cycle its done pulse is out
  assign w_i_elig = bus.i_req & ~r_i_done;
  assign w_d_elig = bus.d_req & ~r_d_done;

`ifdef SRAM_ARB_RR_EN
  logic r_last_d;
  assign w_pick_d = w_d_elig & (~w_i_elig | ~r_last_d);
`else
  assign w_pick_d = w_d_elig;
`endif

  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_timeout = (w_cnt_nxt == CNT_W'(WAIT_MAX));

  always_ff @(posedge Hclock or negedge Hreset) begin
    if (!Hreset) begin
      r_state   <= ST_IDLE;
      r_grant_d <= 1'b0;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_size    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_select  <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_d_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
`ifdef SRAM_ARB_RR_EN
      r_last_d  <= 1'b0;
`endif
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_d_err  <= 1'b0;
      r_select <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_i_elig || w_d_elig) begin
            r_grant_d <= w_pick_d;
            r_write   <= w_pick_d ? bus.d_write : 1'b0;
            r_size    <= w_pick_d ? bus.d_size  : 1'b1;
            r_addr    <= w_pick_d ? bus.d_addr  : bus.i_addr;
            r_wdata   <= w_pick_d ? bus.d_wdata : r_wdata;
            r_select  <= 1'b1;
            r_state   <= ST_ISSUE;
`ifdef SRAM_ARB_RR_EN
            r_last_d  <= w_pick_d;
`endif
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.m_hready) begin
            if (!r_write) begin
              if (r_grant_d) r_d_rdata <= bus.m_rdata;
              else           r_i_rdata <= bus.m_rdata;
            end
            r_d_done <= r_grant_d;
            r_i_done <= ~r_grant_d;
            r_state  <= ST_IDLE;
          end else if (w_timeout) begin
            r_d_done <= r_grant_d;
            r_i_done <= ~r_grant_d;
            r_d_err  <= r_grant_d;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.i_done   = r_i_done;
  assign bus.i_rdata  = r_i_rdata;
  assign bus.d_done   = r_d_done;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.d_err    = r_d_err;
  assign bus.m_select = r_select;
  assign bus.m_ready  = r_select;
  assign bus.m_write  = r_write;
  assign bus.m_size   = r_size;
  assign bus.m_addr   = r_addr;
  assign bus.m_wdata  = r_wdata;

endmodule
